seq_multiplier: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the inverse operation of the team's restoring divider datapath and uses the same operand-bus and start/done style.
- Multiplies a WIDTH-bit multiplicand by a WIDTH-bit multiplier and produces a 2*WIDTH-bit product, one partial product per clock.
- Contains its own controller FSM and datapath, and sits beside the divider in the arithmetic unit.

---
 rtl/seq_multiplier.sv | 99 +++++++++
 tb/tb_seq_multiplier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per clock.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   MBus,
    input  logic [WIDTH-1:0]   QBus,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic               ready
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
    logic               c_q, c_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     sum;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sum       = {c_q, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Unprocessed multiplier bits moved to the top; all zero means nothing left to add.
        rem       = q_q << (WIDTH - int'(cnt_q));
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = MBus;
                    q_d     = QBus;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Add and shift in one step: the sum's carry lands in the accumulator MSB.
                c_d          = 1'b0;
                {a_d, q_d}   = {sum, q_q[WIDTH-1:1]};
                cnt_d        = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = {sum, q_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (rem == '0) begin
                    product_d = (2*WIDTH)'({c_q, a_q, q_q} >> cnt_q);
                    state_d   = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign ready   = (state_q == IDLE);
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random operations against an arithmetic reference model.
module tb_seq_multiplier;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] MBus = '0;
  logic [W-1:0] QBus = '0;
  logic [2*W-1:0] product;
  logic busy, done, ready;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_prod = '0;
  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .MBus(MBus), .QBus(QBus),
    .product(product), .busy(busy), .done(done), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic [2*W-1:0] mm, qq;
    mm = {{W{1'b0}}, m};
    qq = {{W{1'b0}}, q};
    return mm * qq;
  endfunction
  function automatic int ref_lat(input logic [W-1:0] q);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int k;
    if (q == '0) return 1;
    k = 0;
    for (int i = 0; i < W; i++) if (q[i]) k = i;
    return (k + 2 < W) ? k + 2 : W;
`else
    return W;
`endif
  endfunction
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q);
    logic [2*W-1:0] exp_p;
    int lat;
    exp_p = ref_mul(m, q);
    lat = ref_lat(q);
    for (int i = 0; i < 50 && !ready; i++) @(posedge clk) #1;
    checks++; if (ready !== 1'b1) fail("ready_before_start", ready, 1'b1);
    start = 1'b1;
    MBus = m;
    QBus = q;
    @(posedge clk) #1;
    start = 1'b0;
    MBus = W'($urandom);
    QBus = W'($urandom);
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk) #1;
      if (j < lat) begin
        checks++; if (busy !== 1'b1) fail("busy_calc", busy, 1'b1);
        checks++; if (product !== last_prod) fail("product_hold", product, last_prod);
      end else begin
        checks++; if (done !== 1'b1) fail("done_at_latency", done, 1'b1);
        checks++; if (product !== exp_p) fail("product", product, exp_p);
      end
    end
    @(posedge clk) #1;
    checks++; if (ready !== 1'b1) fail("ready_after_done", ready, 1'b1);
    checks++; if (done !== 1'b0) fail("done_one_cycle", done, 1'b0);
    last_prod = exp_p;
  endtask
  initial begin
    int dones;
    logic prev_done;
    logic [W-1:0] rq;
    #12;
    checks++; if (product !== 32'h0) fail("reset_product", product, 32'h0);
    checks++; if (ready !== 1'b1) fail("reset_ready", ready, 1'b1);
    checks++; if (busy !== 1'b0) fail("reset_busy", busy, 1'b0);
    checks++; if (done !== 1'b0) fail("reset_done", done, 1'b0);
    @(negedge clk) rst = 1'b1;
    run_op(16'd3, 16'd5);
    checks++; if (product !== 32'h0000000F) fail("prod_3x5", product, 32'h0000000F);
    run_op(16'hFFFF, 16'hFFFF);
    checks++; if (product !== 32'hFFFE0001) fail("prod_max", product, 32'hFFFE0001);
    run_op(16'h1234, 16'h0000);
    run_op(16'h0000, 16'hABCD);
    run_op(16'h1234, 16'h0003);
    checks++; if (product !== 32'h0000369C) fail("prod_1234x3", product, 32'h0000369C);
    start = 1'b1;
    MBus = 16'h1234;
    QBus = 16'h0F0F;
    @(posedge clk) #1;
    dones = 0;
    prev_done = 1'b0;
    for (int e = 1; e < 4 * W + 10; e++) begin
      @(posedge clk) #1;
      if (e == 4) begin
        MBus = 16'd7;
        QBus = 16'd7;
      end
      if (done) begin
        dones++;
        checks++; if (prev_done !== 1'b0) fail("held_done_pulse", prev_done, 1'b0);
        if (dones == 1) begin
          checks++; if (product !== ref_mul(16'h1234, 16'h0F0F)) fail("held_first", product, ref_mul(16'h1234, 16'h0F0F));
        end
        if (dones == 2) begin
          checks++; if (product !== 32'd49) fail("held_second", product, 32'd49);
          break;
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (dones != 2) fail("held_done_count", dones, 2);
    last_prod = 32'd49;
    for (int i = 0; i < 50 && !ready; i++) @(posedge clk) #1;
    start = 1'b1;
    MBus = 16'h00FF;
    QBus = 16'h0101;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (product !== 32'h0) fail("rst_product", product, 32'h0);
    checks++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
    checks++; if (done !== 1'b0) fail("rst_done", done, 1'b0);
    checks++; if (ready !== 1'b1) fail("rst_ready", ready, 1'b1);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(posedge clk) #1;
      checks++; if (done !== 1'b0) fail("no_done_after_rst", done, 1'b0);
    end
    last_prod = '0;
    run_op(16'h00FF, 16'h0101);
    checks++; if (product !== 32'h0000FFFF) fail("prod_ff_x_101", product, 32'h0000FFFF);
    run_op(16'd10, 16'd20);
    checks++; if (product !== 32'd200) fail("prod_10x20", product, 32'd200);
    run_op(16'h8000, 16'd2);
    checks++; if (product !== 32'h00010000) fail("prod_8000x2", product, 32'h00010000);
    for (int n = 0; n < 24; n++) begin
      rq = W'($urandom) >> $urandom_range(0, W - 1);
      run_op(W'($urandom), rq);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=hung expected=finished");
    $fatal(1, "timeout");
  end
endmodule
